// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state type, default geometry and parameter sanity check for the I2S transmitter.
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_SLOT_BITS = 16;
  localparam int DEF_BCK_DIV = 1;
  function automatic bit params_ok(input int data_w, input int slot_bits, input int bck_div);
    return slot_bits >= data_w && bck_div >= 1;
  endfunction
endpackage

// File: rtl/i2s_bck_gen.sv
// i2s_bck_gen: divides clk_i down to the I2S bit clock and flags each falling BCK edge as a tick.
module i2s_bck_gen import i2s_pkg::*; #(
  parameter int BCK_DIV = DEF_BCK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bck_o,
  output logic tick_o
);
  localparam int CW = BCK_DIV > 1 ? $clog2(BCK_DIV) : 1;
  logic [CW-1:0] div_d, div_q;
  logic bck_d, bck_q, term;
  always_comb begin
    term = div_q == CW'(BCK_DIV - 1);
    div_d = (clr_i || term) ? '0 : div_q + 1'b1;
    bck_d = clr_i ? 1'b0 : bck_q ^ term;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      bck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bck_q <= bck_d;
    end
  end
  assign tick_o = term && bck_q && !clr_i;
  assign bck_o = bck_q;
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: stereo PCM to I2S (BCK/WS/DIN) with a one-deep sample buffer and underrun repeat.
module i2s_tx_serializer import i2s_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int BCK_DIV = DEF_BCK_DIV
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_left_i,
  input  logic [DATA_W-1:0] s_right_i,
  output logic              hp_bck_o,
  output logic              hp_ws_o,
  output logic              hp_din_o,
  output logic              frame_o,
  output logic              underrun_o
);
  localparam int FW = 2 * SLOT_BITS;
  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0] B_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] WS_LO = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] WS_HI = BW'(FW - 2);
  if (!params_ok(DATA_W, SLOT_BITS, BCK_DIV)) begin : g_bad_params
    $error("i2s_tx_serializer: SLOT_BITS must be >= DATA_W and BCK_DIV >= 1");
  end
  state_e state_d, state_q;
  logic [BW-1:0] b_d, b_q;
  logic [FW-1:0] sr_d, sr_q, frame_w;
  logic [SLOT_BITS-1:0] l_slot, r_slot;
  logic [DATA_W-1:0] buf_l_d, buf_l_q, buf_r_d, buf_r_q, last_l_d, last_l_q, last_r_d, last_r_q;
  logic full_d, full_q, ready_d, ready_q, primed_d, primed_q;
  logic ws_d, ws_q, din_d, din_q, frame_d, frame_q, under_d, under_q;
  logic tick, accept, wrap, active, load, drain_end;
  i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q == IDLE),
    .bck_o  (hp_bck_o),
    .tick_o (tick)
  );
  always_comb begin
    accept = s_valid_i && !full_q;
    wrap = b_q == B_LAST;
    active = state_q == RUN || (state_q == DRAIN && en_i);
    // primed_q is clear until the first load after IDLE, so that first tick loads regardless of b
    load = tick && active && (wrap || !primed_q);
    drain_end = state_q == DRAIN && !en_i && (!primed_q || (tick && wrap));
    l_slot = '0;
    r_slot = '0;
    l_slot[SLOT_BITS-1 -: DATA_W] = full_q ? buf_l_q : last_l_q;
    r_slot[SLOT_BITS-1 -: DATA_W] = full_q ? buf_r_q : last_r_q;
    frame_w = {l_slot, r_slot};
    full_d = accept || (full_q && !load);
    ready_d = !full_d;
    buf_l_d = accept ? s_left_i : buf_l_q;
    buf_r_d = accept ? s_right_i : buf_r_q;
    last_l_d = (load && full_q) ? buf_l_q : last_l_q;
    last_r_d = (load && full_q) ? buf_r_q : last_r_q;
    frame_d = load;
    under_d = load && !full_q;
    primed_d = primed_q || load;
    b_d = load ? '0 : tick ? b_q + 1'b1 : b_q;
    sr_d = load ? frame_w : tick ? sr_q << 1 : sr_q;
    din_d = tick ? sr_d[FW-1] : din_q;
    ws_d = tick ? (b_d >= WS_LO && b_d <= WS_HI) : ws_q;
    state_d = state_q == IDLE ? (en_i ? RUN : IDLE)
            : state_q == RUN  ? (en_i ? RUN : DRAIN)
            : en_i ? RUN : drain_end ? IDLE : DRAIN;
    if (drain_end || state_q == IDLE) begin
      b_d = '0;
      sr_d = '0;
      din_d = 1'b0;
      ws_d = 1'b0;
      primed_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      b_q <= '0;
      sr_q <= '0;
      buf_l_q <= '0;
      buf_r_q <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
      full_q <= 1'b0;
      ready_q <= 1'b1;
      primed_q <= 1'b0;
      ws_q <= 1'b0;
      din_q <= 1'b0;
      frame_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      sr_q <= sr_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
      full_q <= full_d;
      ready_q <= ready_d;
      primed_q <= primed_d;
      ws_q <= ws_d;
      din_q <= din_d;
      frame_q <= frame_d;
      under_q <= under_d;
    end
  end
  assign s_ready_o = ready_q;
  assign hp_ws_o = ws_q;
  assign hp_din_o = din_q;
  assign frame_o = frame_q;
  assign underrun_o = under_q;
endmodule
